// File: rtl/activity_4_pkg.sv
// rtl/activity_4_pkg.sv - shared state encodings for the bit-serial adder/subtractor
package activity_4_pkg;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/activity_4_fa_cell.sv
// rtl/activity_4_fa_cell.sv - one-bit combinational full adder cell
module activity_4_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/activity_4_serial_addsub.sv
// rtl/activity_4_serial_addsub.sv - bit-serial add/sub, one bit per clock, LSB first
module activity_4_serial_addsub
    import activity_4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic [WIDTH:0]   res_cat;
    logic             carry;
    logic [CW-1:0]    count;
    logic             cell_s;
    logic             cell_c;
    logic             last_bit;
    logic             load;
    logic             shift_en;

    activity_4_fa_cell u_cell (
        .a    (opa[0]),
        .b    (opb[0]),
        .cin  (carry),
        .s    (cell_s),
        .cout (cell_c)
    );

    // Concatenate-then-slice so the MSB insert also works when WIDTH is 1.
    assign res_cat  = {cell_s, res};
    assign last_bit = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = ST_IDLE;
        case (state)
            ST_IDLE: state_nx = start ? ST_RUN : ST_IDLE;
            ST_RUN:  state_nx = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == ST_RUN) || (state == ST_DONE);
        load     = (state == ST_IDLE) && start;
        shift_en = (state == ST_RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            count <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= shift_en && last_bit;
            if (load) begin
                // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub;
                count <= '0;
            end else if (shift_en) begin
                opa   <= opa >> 1;
                opb   <= opb >> 1;
                res   <= res_cat[WIDTH:1];
                carry <= cell_c;
                count <= count + CW'(1);
                if (last_bit) begin
                    sum  <= res_cat[WIDTH:1];
                    cout <= cell_c;
                    ovf  <= carry ^ cell_c;
                end
            end
        end
    end

endmodule
